// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver FSM state encoding and default frame geometry.
package uart_rx_pkg;
  localparam int DEFAULT_DIVIDER = 4096;
  localparam int DEFAULT_CHAR_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK} rx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter with a half-period load for start-bit centring.
module uart_bit_timer #(
  parameter int DIVIDER = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic half_load_i,
  output logic tick_o
);
  localparam int TW = $clog2(DIVIDER);
  logic [TW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == '0;
  always_comb cnt_d = half_load_i ? TW'(DIVIDER / 2 - 1) : tick_o ? TW'(DIVIDER - 1) : cnt_q - TW'(1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= TW'(DIVIDER - 1);
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: framed UART receiver with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits.
module uart_rx_framed
  import uart_rx_pkg::*;
#(
  parameter int DIVIDER = DEFAULT_DIVIDER,
  parameter int CHAR_W = DEFAULT_CHAR_W,
  parameter int STOP_BITS = 1,
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clock_50M,
  input  logic              n_reset,
  input  logic              uart_rx_pin,
  output logic [CHAR_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              framing_error,
  output logic              parity_error,
  output logic              overrun
);
  localparam int IW = 4;
  localparam logic [IW-1:0] LAST_DATA = IW'(CHAR_W - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic line, prev_q, tick, half_load;
  rx_state_t state_q, state_d;
  logic [CHAR_W-1:0] sr_q, sr_d, rx_data_q, rx_data_d;
  logic [IW-1:0] idx_q, idx_d;
  logic stop_bad_q, stop_bad_d, parity_bad_q, parity_bad_d;
  logic rx_valid_q, rx_valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
`endif
  assign line = sync_q[SYNC_STAGES-1];
  uart_bit_timer #(.DIVIDER(DIVIDER)) u_timer (
    .clk_i(clock_50M),
    .rst_ni(n_reset),
    .half_load_i(half_load),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    idx_d = idx_q;
    stop_bad_d = stop_bad_q;
    parity_bad_d = parity_bad_q;
    rx_data_d = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    ferr_d = 1'b0;
    ovr_d = 1'b0;
    half_load = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d = 1'b0;
`endif
    case (state_q)
      // prev_q must be 1 so a line that never returned high cannot re-arm
      IDLE: if (prev_q & ~line) begin
        state_d = START;
        half_load = 1'b1;
        idx_d = '0;
        stop_bad_d = 1'b0;
        parity_bad_d = 1'b0;
      end
      START: if (tick) state_d = line ? IDLE : DATA;
      DATA: if (tick) begin
        sr_d = {line, sr_q[CHAR_W-1:1]};
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_DATA) begin
          idx_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (tick) begin
        parity_bad_d = line != (^sr_q ^ PARITY_ODD);
        state_d = STOP;
      end
      STOP: if (tick) begin
        stop_bad_d = stop_bad_q | ~line;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_STOP) begin
          state_d = stop_bad_d ? BREAK : DELIVER;
          ferr_d = stop_bad_d;
        end
      end
      DELIVER: begin
        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
        perr_d = parity_bad_q;
`endif
        if (!parity_bad_q) begin
          if (!rx_valid_q || rx_ready) begin
            rx_data_d = sr_q;
            rx_valid_d = 1'b1;
          end else ovr_d = 1'b1;
        end
      end
      BREAK: if (line) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_50M or negedge n_reset)
    if (!n_reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      state_q <= IDLE;
      sr_q <= '0;
      idx_q <= '0;
      stop_bad_q <= 1'b0;
      parity_bad_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_pin};
      prev_q <= line;
      state_q <= state_d;
      sr_q <= sr_d;
      idx_q <= idx_d;
      stop_bad_q <= stop_bad_d;
      parity_bad_q <= parity_bad_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock_50M or negedge n_reset)
    if (!n_reset) perr_q <= 1'b0;
    else perr_q <= perr_d;
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign framing_error = ferr_q;
  assign overrun = ovr_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed frames against a bit-period timing model of the receiver.
module tb_uart_rx_framed;
  localparam int DIV = 16;
  localparam int STOPS = 1;
  localparam bit PODD = 1'b0;
  logic clk = 1'b0, n_reset = 1'b0, pin = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, busy, framing_error, parity_error, overrun;
  int checks = 0, errors = 0;
  bit run = 1'b0;
  int cyc = 0, commit_at = -1, ferr_at = -1;
  logic [7:0] pend_data = '0, m_data = '0;
  bit pend_perr = 1'b0, m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  int vcnt = 0, fcnt = 0, ocnt = 0, pcnt = 0;
  logic [7:0] last_d = '0;

  uart_rx_framed #(.DIVIDER(DIV), .CHAR_W(8), .STOP_BITS(STOPS), .SYNC_STAGES(2), .PARITY_ODD(PODD)) dut (
    .clock_50M(clk), .n_reset(n_reset), .uart_rx_pin(pin), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .framing_error(framing_error), .parity_error(parity_error),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame whose start edge is driven just after posedge c is sampled bit by bit
  // mid-period; its last bit K is taken at posedge c+11+16K and committed one edge later.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_valid = 1'b0; m_data = '0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      commit_at = -1; ferr_at = -1;
    end else begin
      bit old_v;
      cyc = cyc + 1;
      m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      old_v = m_valid;
      if (old_v && rx_ready) m_valid = 1'b0;
      if (cyc == commit_at) begin
        if (pend_perr) m_perr = 1'b1;
        else if (!old_v || rx_ready) begin m_valid = 1'b1; m_data = pend_data; end
        else m_ovr = 1'b1;
      end
      if (cyc == ferr_at) m_ferr = 1'b1;
    end
  end

  always @(negedge clk) if (n_reset && run) begin
    chk("rx_valid", {15'd0, rx_valid}, {15'd0, m_valid});
    if (m_valid) chk("rx_data", {8'd0, rx_data}, {8'd0, m_data});
    chk("framing_error", {15'd0, framing_error}, {15'd0, m_ferr});
    chk("overrun", {15'd0, overrun}, {15'd0, m_ovr});
    chk("parity_error", {15'd0, parity_error}, {15'd0, m_perr});
  end

  always @(negedge clk) if (n_reset) begin
    if (rx_valid) begin vcnt++; last_d = rx_data; end
    if (framing_error) fcnt++;
    if (overrun) ocnt++;
    if (parity_error) pcnt++;
  end

  task automatic clr();
    @(posedge clk);
    vcnt = 0; fcnt = 0; ocnt = 0; pcnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input bit stop_v, input bit pflip, input int tail_low);
    logic [15:0] fr;
    int n, c;
    fr = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin fr[n] = d[i]; n++; end
`ifdef UART_RX_PARITY_EN
    fr[n] = (^d) ^ PODD ^ pflip; n++;
`endif
    for (int i = 0; i < STOPS; i++) begin fr[n] = stop_v; n++; end
    @(negedge clk);
    c = cyc;
    if (stop_v) begin
      pend_data = d; pend_perr = pflip; commit_at = c + 12 + DIV * (n - 1);
    end else ferr_at = c + 11 + DIV * (n - 1);
    for (int i = 0; i < n; i++) begin
      pin = fr[i];
      repeat (DIV) @(negedge clk);
    end
    repeat (tail_low) @(negedge clk);
    pin = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic after();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_valid", {15'd0, rx_valid}, 16'd0);
    chk("reset rx_data", {8'd0, rx_data}, 16'd0);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset framing_error", {15'd0, framing_error}, 16'd0);
    chk("reset overrun", {15'd0, overrun}, 16'd0);
    chk("reset parity_error", {15'd0, parity_error}, 16'd0);
    @(negedge clk);
    n_reset = 1'b1;
    run = 1'b1;
    repeat (4) @(negedge clk);
    clr();
    send(8'hA5, 1'b1, 1'b0, 0);
    after();
    chk("t1 valid cycles", 16'(vcnt), 16'd1);
    chk("t1 data", {8'd0, last_d}, 16'h00A5);
    chk("t1 errors", 16'(fcnt + ocnt + pcnt), 16'd0);
    @(negedge clk);
    rx_ready = 1'b0;
    clr();
    send(8'h3C, 1'b1, 1'b0, 0);
    send(8'h7E, 1'b1, 1'b0, 0);
    after();
    chk("t2 held data", {8'd0, rx_data}, 16'h003C);
    chk("t2 held valid", {15'd0, rx_valid}, 16'd1);
    chk("t2 overrun pulses", 16'(ocnt), 16'd1);
    @(negedge clk);
    rx_ready = 1'b1;
    after();
    chk("t2 valid cleared", {15'd0, rx_valid}, 16'd0);
    clr();
    @(negedge clk);
    pin = 1'b0;
    repeat (4) @(negedge clk);
    pin = 1'b1;
    repeat (30) @(negedge clk);
    chk("t3 no valid", 16'(vcnt), 16'd0);
    chk("t3 no error", 16'(fcnt + ocnt + pcnt), 16'd0);
    chk("t3 idle", {15'd0, busy}, 16'd0);
    clr();
    send(8'h55, 1'b0, 1'b0, 40);
    after();
    chk("t4 framing pulses", 16'(fcnt), 16'd1);
    chk("t4 no valid", 16'(vcnt), 16'd0);
    clr();
    send(8'h12, 1'b1, 1'b0, 0);
    after();
    chk("t4 recovery data", {8'd0, last_d}, 16'h0012);
    chk("t4 recovery valid", 16'(vcnt), 16'd1);
`ifdef UART_RX_PARITY_EN
    clr();
    send(8'h07, 1'b1, 1'b0, 0);
    after();
    chk("t5 good parity data", {8'd0, last_d}, 16'h0007);
    chk("t5 good parity valid", 16'(vcnt), 16'd1);
    chk("t5 good parity no error", 16'(pcnt), 16'd0);
    clr();
    send(8'h07, 1'b1, 1'b1, 0);
    after();
    chk("t5 bad parity pulses", 16'(pcnt), 16'd1);
    chk("t5 bad parity no valid", 16'(vcnt), 16'd0);
`endif
    clr();
    fork
      send(8'hFF, 1'b1, 1'b0, 0);
      begin
        @(negedge clk);
        repeat (86) @(negedge clk);
        chk("t6 busy mid frame", {15'd0, busy}, 16'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("t6 reset rx_valid", {15'd0, rx_valid}, 16'd0);
        chk("t6 reset rx_data", {8'd0, rx_data}, 16'd0);
        chk("t6 reset busy", {15'd0, busy}, 16'd0);
        chk("t6 reset pulses", {13'd0, framing_error, overrun, parity_error}, 16'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
      end
    join
    after();
    chk("t6 aborted frame", 16'(vcnt), 16'd0);
    clr();
    send(8'h81, 1'b1, 1'b0, 0);
    after();
    chk("t6 next data", {8'd0, last_d}, 16'h0081);
    chk("t6 next valid", 16'(vcnt), 16'd1);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
